// File: rtl/i2c_scl_timebase.sv
// Standard-mode SCL generator with clock-stretch hold, plus a synchronised,
// glitch-filtered SCL read-back path with single-cycle edge strobes.
module i2c_scl_timebase #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned SCL_FREQ_HZ = 100_000,
    parameter int unsigned STAGES      = 2
) (
    input  logic CLK,
    input  logic rst,
    input  logic stretch_en,
    input  logic scl_o,
    output logic scl_i,
    output logic scl_filt,
    output logic scl_rise,
    output logic scl_fall
);

    localparam int unsigned HALF = CLK_FREQ_HZ / (2 * SCL_FREQ_HZ);
    localparam int unsigned CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF - 1);

    generate
        if (HALF < 2) begin : g_half_chk
            $error("i2c_scl_timebase: HALF must be at least 2");
        end
        if (STAGES < 1 || STAGES > 8) begin : g_stages_chk
            $error("i2c_scl_timebase: STAGES must be in 1..8");
        end
    endgenerate

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              scl_q, scl_d;
    logic              s1_q, s2_q;
    logic [STAGES-1:0] h_q, h_d;
    logic              filt_q, filt_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic              hold;
    logic              all_ones, all_zeros;

    // Another master holding SCL low while we release it freezes the high phase.
    assign hold = stretch_en & scl_q & ~filt_q;

    always_comb begin
        cnt_d = cnt_q;
        scl_d = scl_q;
        if (!hold) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                scl_d = ~scl_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    generate
        if (STAGES == 1) begin : g_hist_one
            assign h_d = s2_q;
        end else begin : g_hist_shift
            assign h_d = {h_q[STAGES-2:0], s2_q};
        end
    endgenerate

    assign all_ones  = &h_q;
    assign all_zeros = ~|h_q;

    always_comb begin
        filt_d = filt_q;
        if (all_ones) begin
            filt_d = 1'b1;
        end else if (all_zeros) begin
            filt_d = 1'b0;
        end
        rise_d = all_ones & ~filt_q;
        fall_d = all_zeros & filt_q;
    end

    always_ff @(posedge CLK) begin
        if (!rst) begin
            cnt_q  <= '0;
            scl_q  <= 1'b1;
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            h_q    <= '1;
            filt_q <= 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            scl_q  <= scl_d;
            s1_q   <= scl_o;
            s2_q   <= s1_q;
            h_q    <= h_d;
            filt_q <= filt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign scl_i    = scl_q;
    assign scl_filt = filt_q;
    assign scl_rise = rise_q;
    assign scl_fall = fall_q;

endmodule

// File: tb/tb_i2c_scl_timebase.sv
// Directed bench for i2c_scl_timebase: default instance (HALF=500, STAGES=2)
// and a swept instance (HALF=250, STAGES=3) sharing clock and reset.
module tb_i2c_scl_timebase;

    localparam int HALF_A = 500;
    localparam int STG_A  = 2;
    localparam int HALF_B = 250;
    localparam int STG_B  = 3;
    localparam int FORCE_CLKS = 300;

    typedef struct {
        int sel;
        int len;
        int exp_low;
        int exp_rise;
        int exp_fall;
        int exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic stretch_a = 1'b0;
    logic loop_a = 1'b0;
    logic force_a = 1'b0;
    logic drv_a = 1'b1;
    logic drv_b = 1'b1;
    logic scl_o_a, scl_o_b;
    logic scl_i_a, scl_filt_a, scl_rise_a, scl_fall_a;
    logic scl_i_b, scl_filt_b, scl_rise_b, scl_fall_b;

    int n_pass = 0;
    int n_total = 0;
    int both_a = 0, both_b = 0;
    int mon_rise_a = 0, mon_fall_a = 0, mon_low_a = 0;

    always #5 clk = ~clk;

    assign scl_o_a = loop_a ? (scl_i_a & ~force_a) : drv_a;
    assign scl_o_b = drv_b;

    i2c_scl_timebase u_dut_a (
        .CLK        (clk),
        .rst        (rst),
        .stretch_en (stretch_a),
        .scl_o      (scl_o_a),
        .scl_i      (scl_i_a),
        .scl_filt   (scl_filt_a),
        .scl_rise   (scl_rise_a),
        .scl_fall   (scl_fall_a)
    );

    i2c_scl_timebase #(
        .CLK_FREQ_HZ (50_000_000),
        .SCL_FREQ_HZ (100_000),
        .STAGES      (3)
    ) u_dut_b (
        .CLK        (clk),
        .rst        (rst),
        .stretch_en (1'b0),
        .scl_o      (scl_o_b),
        .scl_i      (scl_i_b),
        .scl_filt   (scl_filt_b),
        .scl_rise   (scl_rise_b),
        .scl_fall   (scl_fall_b)
    );

    always @(negedge clk) begin
        if (scl_rise_a && scl_fall_a) both_a <= both_a + 1;
        if (scl_rise_b && scl_fall_b) both_b <= both_b + 1;
        if (scl_rise_a) mon_rise_a <= mon_rise_a + 1;
        if (scl_fall_a) mon_fall_a <= mon_fall_a + 1;
        if (!scl_filt_a) mon_low_a <= mon_low_a + 1;
    end

    function automatic logic sci(input int s);
        return (s == 0) ? scl_i_a : scl_i_b;
    endfunction

    function automatic logic sfilt(input int s);
        return (s == 0) ? scl_filt_a : scl_filt_b;
    endfunction

    function automatic logic srise(input int s);
        return (s == 0) ? scl_rise_a : scl_rise_b;
    endfunction

    function automatic logic sfall(input int s);
        return (s == 0) ? scl_fall_a : scl_fall_b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic set_drv(input int s, input logic v);
        if (s == 0) drv_a = v;
        else drv_b = v;
    endtask

    // Edges until scl_i reaches val; -1 when the budget runs out.
    task automatic wait_level(input int s, input logic val, input int budget, output int n);
        n = 0;
        while (sci(s) !== val && n < budget) begin
            step();
            n++;
        end
        if (sci(s) !== val) n = -1;
    endtask

    task automatic run_glitch(input vec_t v, output int low, output int rises,
                              output int falls, output int lat);
        low = 0;
        rises = 0;
        falls = 0;
        lat = -1;
        set_drv(v.sel, 1'b0);
        for (int i = 1; i <= 30; i++) begin
            step();
            if (i == v.len) set_drv(v.sel, 1'b1);
            if (!sfilt(v.sel)) low++;
            if (srise(v.sel)) rises++;
            if (sfall(v.sel)) begin
                falls++;
                if (lat < 0) lat = i - 1;
            end
        end
    endtask

    initial begin
        vec_t vecs[7];
        int n, hi, lo, m, r, f, low, rises, falls, lat;
        int snap_r, snap_f, snap_l;

        // Latency counts edges from the first edge sampling the new level.
        vecs[0] = '{sel: 0, len: 1, exp_low: 0, exp_rise: 0, exp_fall: 0, exp_lat: -1};
        vecs[1] = '{sel: 0, len: 2, exp_low: 2, exp_rise: 1, exp_fall: 1, exp_lat: 4};
        vecs[2] = '{sel: 0, len: 4, exp_low: 4, exp_rise: 1, exp_fall: 1, exp_lat: 4};
        vecs[3] = '{sel: 1, len: 1, exp_low: 0, exp_rise: 0, exp_fall: 0, exp_lat: -1};
        vecs[4] = '{sel: 1, len: 2, exp_low: 0, exp_rise: 0, exp_fall: 0, exp_lat: -1};
        vecs[5] = '{sel: 1, len: 3, exp_low: 3, exp_rise: 1, exp_fall: 1, exp_lat: 5};
        vecs[6] = '{sel: 1, len: 6, exp_low: 6, exp_rise: 1, exp_fall: 1, exp_lat: 5};

        repeat (5) step();
        chk("rst_scl_i_a", int'(scl_i_a), 1);
        chk("rst_filt_a", int'(scl_filt_a), 1);
        chk("rst_strobes_a", int'(scl_rise_a) + int'(scl_fall_a), 0);
        chk("rst_scl_i_b", int'(scl_i_b), 1);
        chk("rst_filt_b", int'(scl_filt_b), 1);
        chk("rst_strobes_b", int'(scl_rise_b) + int'(scl_fall_b), 0);

        // Free-running, scl_o tied high.
        snap_r = mon_rise_a;
        snap_f = mon_fall_a;
        snap_l = mon_low_a;
        rst = 1'b1;
        wait_level(0, 1'b0, 1100, hi);
        chk("first_high_a", hi, HALF_A);
        wait_level(0, 1'b1, 1100, lo);
        chk("first_low_a", lo, HALF_A);
        wait_level(0, 1'b0, 1100, n);
        chk("period_a", lo + n, 2 * HALF_A);
        chk("idle_rise_a", mon_rise_a - snap_r, 0);
        chk("idle_fall_a", mon_fall_a - snap_f, 0);
        chk("idle_filt_low_a", mon_low_a - snap_l, 0);

        // Loopback.
        loop_a = 1'b1;
        wait_level(0, 1'b1, 1100, n);
        wait_level(0, 1'b0, 1100, n);
        m = 0;
        while (!scl_fall_a && m < 20) begin
            step();
            m++;
        end
        chk("loop_fall_lat_a", m, 2 + STG_A + 1);
        r = 0;
        f = 0;
        repeat (2 * HALF_A) begin
            step();
            if (scl_rise_a) r++;
            if (scl_fall_a) f++;
        end
        chk("loop_rises_a", r, 1);
        chk("loop_falls_a", f, 1);

        // Stretch: scl_o held low for FORCE_CLKS sampled edges from the rise.
        stretch_a = 1'b1;
        wait_level(0, 1'b0, 1200, n);
        wait_level(0, 1'b1, 1200, n);
        force_a = 1'b1;
        repeat (FORCE_CLKS) step();
        force_a = 1'b0;
        wait_level(0, 1'b0, 2000, n);
        chk("stretch_high_a", (n < 0) ? -1 : FORCE_CLKS + n, HALF_A + FORCE_CLKS + 2 + STG_A + 1);
        wait_level(0, 1'b1, 1200, lo);
        chk("stretch_low_a", lo, HALF_A);

        // Reset in the middle of a high phase, filtered level low beforehand.
        stretch_a = 1'b0;
        loop_a = 1'b0;
        drv_a = 1'b1;
        wait_level(0, 1'b0, 1200, n);
        wait_level(0, 1'b1, 1200, n);
        repeat (240) step();
        drv_a = 1'b0;
        repeat (10) step();
        chk("pre_reset_filt_a", int'(scl_filt_a), 0);
        rst = 1'b0;
        step();
        chk("midrst_scl_i_a", int'(scl_i_a), 1);
        chk("midrst_filt_a", int'(scl_filt_a), 1);
        chk("midrst_strobes_a", int'(scl_rise_a) + int'(scl_fall_a), 0);
        drv_a = 1'b1;
        step();
        rst = 1'b1;
        wait_level(0, 1'b0, 1100, n);
        chk("midrst_next_fall_a", n, HALF_A);

        // Swept instance period.
        wait_level(1, 1'b0, 600, n);
        wait_level(1, 1'b1, 600, lo);
        wait_level(1, 1'b0, 600, hi);
        chk("low_b", lo, HALF_B);
        chk("period_b", (lo < 0 || hi < 0) ? -1 : lo + hi, 2 * HALF_B);

        repeat (20) step();
        for (int i = 0; i < 7; i++) begin
            run_glitch(vecs[i], low, rises, falls, lat);
            chk($sformatf("glitch%0d_low", i), low, vecs[i].exp_low);
            chk($sformatf("glitch%0d_rise", i), rises, vecs[i].exp_rise);
            chk($sformatf("glitch%0d_fall", i), falls, vecs[i].exp_fall);
            chk($sformatf("glitch%0d_lat", i), lat, vecs[i].exp_lat);
        end

        chk("both_strobes_a", both_a, 0);
        chk("both_strobes_b", both_b, 0);
        chk("stg_b_latency_gap", vecs[5].exp_lat - vecs[1].exp_lat, STG_B - STG_A);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
